// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, defaults and
// the address legality check used when a response is formed.
package mem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Misaligned byte address or word index past the end of storage.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, asynchronous read, contents never reset.
module mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_resp.sv
// M-stage data memory with programmable wait states: captures a request,
// waits WAIT_CYCLES, performs the access and returns a one-cycle ready pulse.
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_stall
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned DEPTH_U   = DEPTH_WORDS;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_we_p0;
  logic [31:0]        req_addr_p0;
  logic [31:0]        req_wdata_p0;

  logic               accept;
  logic               go_resp;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic               sel_err;
  logic [AW-1:0]      word_idx;
  logic [DATA_W-1:0]  rd_word;
  logic               arr_we;

  // The ready cycle itself is spent in IDLE; blocking acceptance there keeps the
  // still-asserted old request from being taken a second time.
  assign accept  = (state == IDLE) && mem_req && !mem_ready;
  assign go_resp = (state == IDLE) ? (accept && NO_WAIT)
                                   : ((state == WAIT) && (cnt == '0));

  // With no wait states the access happens on the accept edge, so the live
  // request is used; otherwise the captured copy.
  assign sel_we    = (state == IDLE) ? mem_we    : req_we_p0;
  assign sel_addr  = (state == IDLE) ? mem_addr  : req_addr_p0;
  assign sel_wdata = (state == IDLE) ? mem_wdata : req_wdata_p0;
  assign sel_err   = addr_err(sel_addr, DEPTH_U);
  assign word_idx  = sel_addr[AW+1:2];
  assign arr_we    = go_resp && sel_we && !sel_err;

  assign mem_stall = mem_req & ~mem_ready;

  mem_array #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (word_idx),
    .wdata (sel_wdata),
    .raddr (word_idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_ready    <= 1'b0;
      mem_err      <= 1'b0;
      mem_rdata    <= '0;
      req_we_p0    <= 1'b0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
    end else begin
      mem_ready <= (state == RESP);
      if (go_resp) begin
        mem_err   <= sel_err;
        mem_rdata <= (sel_we || sel_err) ? '0 : rd_word;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            req_we_p0    <= mem_we;
            req_addr_p0  <= mem_addr;
            req_wdata_p0 <= mem_wdata;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
